// File: rtl/tb_checker_pkg.sv
// Shared types and helpers for the multi-channel result checker.
package tb_checker_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   typedef enum logic {MISMATCH, UNDERFLOW} err_kind_t;

   // Wide enough for a signed difference of any result word up to 64 bits
   localparam int unsigned DIFF_W = 65;

   function automatic logic [DIFF_W-1:0] abs_diff(input logic signed [DIFF_W-1:0] a,
                                                  input logic signed [DIFF_W-1:0] b);
      logic signed [DIFF_W-1:0] d;
      d = a - b;
      return (d < 0) ? DIFF_W'(-d) : DIFF_W'(d);
   endfunction

endpackage

// File: rtl/tb_multi_ch_result_checker_if.sv
// Expected-word write port and DUT result port of the multi-channel checker.
interface tb_multi_ch_result_checker_if #(
   parameter int unsigned N_CH   = 4,
   parameter int unsigned DATA_W = 32
);
   logic [N_CH-1:0]        exp_wr_en;
   logic [N_CH*DATA_W-1:0] exp_wr_data;
   logic [N_CH-1:0]        exp_full;
   logic [N_CH-1:0]        dut_vld;
   logic [N_CH*DATA_W-1:0] dut_data;

   modport master (output exp_wr_en, exp_wr_data, dut_vld, dut_data, input exp_full);
   modport slave  (input exp_wr_en, exp_wr_data, dut_vld, dut_data, output exp_full);
endinterface

// File: rtl/tb_exp_fifo.sv
// Per-channel expected-word FIFO; pointers carry an extra wrap bit to tell full from empty.
module tb_exp_fifo #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned EXP_DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data_c,
   output logic              full_c,
   output logic              empty_c
);
   localparam int unsigned AW = $clog2(EXP_DEPTH);

   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic [DATA_W-1:0] mem [EXP_DEPTH];
   logic              wr_ok;
   logic              rd_ok;

   assign empty_c   = (wr_ptr == rd_ptr);
   assign full_c    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_data_c = mem[rd_ptr[AW-1:0]];
   // A full FIFO still takes a write when the head leaves in the same cycle
   assign wr_ok     = wr_en && (!full_c || rd_en);
   assign rd_ok     = rd_en && !empty_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (rd_ok) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/tb_multi_ch_result_checker.sv
// Multi-channel result checker: compares DUT beats against per-channel expected FIFOs.
// Optional DISPLAY_ERRORS_EN prints each error and a summary on entering DONE.
module tb_multi_ch_result_checker
   import tb_checker_pkg::*;
#(
   parameter int unsigned N_CH      = 4,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned EXP_DEPTH = 16,
   parameter int unsigned CNT_W     = 32,
   parameter int unsigned TOL       = 0,
   parameter int unsigned TIMEOUT   = 10000,
   localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   tb_multi_ch_result_checker_if.slave bus,
   input  logic                        start,
   input  logic [CNT_W-1:0]            n_expected,
   output logic                        done,
   output logic                        pass,
   output logic [CNT_W-1:0]            err_cnt,
   output logic [CNT_W-1:0]            match_cnt,
   output logic                        timeout_flag,
   output logic                        ovf_flag,
   output logic [CH_W-1:0]             first_err_ch,
   output logic [CNT_W-1:0]            first_err_idx
);
   localparam int unsigned ADD_W = $clog2(N_CH + 1);
   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);

   state_t                    state;
   logic [CNT_W-1:0]          n_exp_q;
   logic [CNT_W-1:0]          idle_cnt;
   logic [CNT_W-1:0]          beat_idx [N_CH];
   logic                      first_seen;

   logic [N_CH-1:0]           fifo_full;
   logic [N_CH-1:0]           fifo_empty;
   logic [N_CH-1:0]           pop;
   logic [N_CH-1:0]           under;
   logic [N_CH-1:0]           good;
   logic [N_CH-1:0]           bad;
   logic [DATA_W-1:0]         head [N_CH];
   logic signed [DATA_W-1:0]  head_s [N_CH];
   logic signed [DATA_W-1:0]  dut_s [N_CH];
   logic [ADD_W-1:0]          match_add;
   logic [ADD_W-1:0]          err_add;
   logic [CH_W-1:0]           fail_ch;
   logic                      fail_found;

   logic                      run_c;
   logic                      any_vld_c;
   logic                      ovf_ev_c;
   logic                      complete_c;
   logic                      tmo_c;
   logic                      done_nxt_c;
   logic                      tmo_nxt_c;
   logic                      ovf_nxt_c;
   logic [CNT_W-1:0]          err_nxt_c;
   logic [CNT_W-1:0]          match_nxt_c;

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      tb_exp_fifo #(.DATA_W(DATA_W), .EXP_DEPTH(EXP_DEPTH)) u_fifo (
         .clk       (clk),
         .rst       (rst),
         .wr_en     (bus.exp_wr_en[c]),
         .wr_data   (bus.exp_wr_data[c*DATA_W +: DATA_W]),
         .rd_en     (pop[c]),
         .rd_data_c (head[c]),
         .full_c    (fifo_full[c]),
         .empty_c   (fifo_empty[c])
      );
      assign head_s[c] = signed'(head[c]);
      assign dut_s[c]  = signed'(bus.dut_data[c*DATA_W +: DATA_W]);
   end

   assign bus.exp_full = fifo_full;
   // A start pulse takes priority over any beats in the same cycle
   assign run_c     = (state == RUN) && !start;
   assign any_vld_c = |bus.dut_vld;

   // Per-channel classification of this cycle's beats
   always_comb begin
      pop        = '0;
      under      = '0;
      good       = '0;
      bad        = '0;
      match_add  = '0;
      err_add    = '0;
      fail_ch    = '0;
      fail_found = 1'b0;
      for (int unsigned c = 0; c < N_CH; c++) begin
         if (run_c && bus.dut_vld[c]) begin
            if (fifo_empty[c]) begin
               under[c] = 1'b1;
               bad[c]   = 1'b1;
            end else begin
               pop[c] = 1'b1;
               if (abs_diff(DIFF_W'(dut_s[c]), DIFF_W'(head_s[c])) > DIFF_W'(TOL)) bad[c]  = 1'b1;
               else                                                             good[c] = 1'b1;
            end
         end
         if (good[c]) match_add = match_add + ADD_W'(1);
         if (bad[c])  err_add   = err_add + ADD_W'(1);
         if (bad[c] && !fail_found) begin
            fail_found = 1'b1;
            fail_ch    = CH_W'(c);
         end
      end
   end

   // Next-cycle status, shared by the state update and the registered pass flag
   always_comb begin
      ovf_ev_c    = |(bus.exp_wr_en & fifo_full & ~pop);
      match_nxt_c = match_cnt + CNT_W'(match_add);
      complete_c  = run_c && ((match_nxt_c + err_cnt + CNT_W'(err_add)) >= n_exp_q);
      tmo_c       = run_c && !complete_c && !any_vld_c && (idle_cnt == IDLE_LAST);
      done_nxt_c  = start ? (n_expected == '0) : ((state == DONE) || complete_c || tmo_c);
      err_nxt_c   = start ? '0 : (err_cnt + CNT_W'(err_add));
      tmo_nxt_c   = !start && (timeout_flag || tmo_c);
      ovf_nxt_c   = ovf_flag || ovf_ev_c;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         n_exp_q       <= '0;
         idle_cnt      <= '0;
         first_seen    <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         err_cnt       <= '0;
         match_cnt     <= '0;
         timeout_flag  <= 1'b0;
         ovf_flag      <= 1'b0;
         first_err_ch  <= '0;
         first_err_idx <= '0;
         for (int unsigned c = 0; c < N_CH; c++) beat_idx[c] <= '0;
      end else begin
         done     <= done_nxt_c;
         pass     <= done_nxt_c && (err_nxt_c == '0) && !tmo_nxt_c && !ovf_nxt_c;
         ovf_flag <= ovf_nxt_c;
         if (start) begin
            state         <= (n_expected == '0) ? DONE : RUN;
            n_exp_q       <= n_expected;
            idle_cnt      <= '0;
            first_seen    <= 1'b0;
            err_cnt       <= '0;
            match_cnt     <= '0;
            timeout_flag  <= 1'b0;
            first_err_ch  <= '0;
            first_err_idx <= '0;
            for (int unsigned c = 0; c < N_CH; c++) beat_idx[c] <= '0;
         end else begin
            case (state)
               RUN: begin
                  match_cnt <= match_nxt_c;
                  err_cnt   <= err_nxt_c;
                  if (any_vld_c)            idle_cnt <= '0;
                  else if (idle_cnt != '1)  idle_cnt <= idle_cnt + CNT_W'(1);
                  for (int unsigned c = 0; c < N_CH; c++) begin
                     if (bus.dut_vld[c]) beat_idx[c] <= beat_idx[c] + CNT_W'(1);
                  end
                  if (fail_found && !first_seen) begin
                     first_seen    <= 1'b1;
                     first_err_ch  <= fail_ch;
                     first_err_idx <= beat_idx[fail_ch];
                  end
                  if (complete_c) begin
                     state <= DONE;
                  end else if (tmo_c) begin
                     state        <= DONE;
                     timeout_flag <= 1'b1;
                  end
               end
               default: state <= state;
            endcase
         end
      end
   end

`ifdef DISPLAY_ERRORS_EN
   always @(posedge clk) begin
      if (!rst) begin
         for (int unsigned c = 0; c < N_CH; c++) begin
            if (bad[c]) begin
               err_kind_t kind;
               kind = under[c] ? UNDERFLOW : MISMATCH;
               $display("%0t checker ch=%0d idx=%0d exp=%h got=%h %s", $time, c, beat_idx[c],
                        under[c] ? '0 : head[c], bus.dut_data[c*DATA_W +: DATA_W], kind.name());
            end
         end
         if (complete_c || tmo_c) begin
            $display("%0t checker finished: match=%0d err=%0d timeout=%0d ovf=%0d", $time,
                     match_nxt_c, err_nxt_c, tmo_nxt_c, ovf_nxt_c);
         end
      end
   end
`endif

endmodule

// File: tb/tb_tb_multi_ch_result_checker.sv
// Randomized and directed bench for the multi-channel result checker (TOL=0 and TOL=1 instances).
module tb_tb_multi_ch_result_checker;
   localparam int unsigned N_CH  = 4;
   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned TMO   = 100;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] n_expected;
   always #5 clk = ~clk;

   tb_multi_ch_result_checker_if #(.N_CH(N_CH), .DATA_W(DW)) if0 ();
   tb_multi_ch_result_checker_if #(.N_CH(N_CH), .DATA_W(DW)) if1 ();
   assign if1.exp_wr_en   = if0.exp_wr_en;
   assign if1.exp_wr_data = if0.exp_wr_data;
   assign if1.dut_vld     = if0.dut_vld;
   assign if1.dut_data    = if0.dut_data;

   logic [1:0]  done_v, pass_v, tmo_v, ovf_v;
   logic [31:0] err_v [2];
   logic [31:0] match_v [2];
   logic [31:0] fidx_v [2];
   logic [1:0]  fch_v [2];
   logic [3:0]  full_v [2];
   assign full_v[0] = if0.exp_full;
   assign full_v[1] = if1.exp_full;

   tb_multi_ch_result_checker #(.N_CH(N_CH), .DATA_W(DW), .EXP_DEPTH(DEPTH), .CNT_W(32),
                                .TOL(0), .TIMEOUT(TMO)) u0 (
      .clk(clk), .rst(rst), .bus(if0), .start(start), .n_expected(n_expected),
      .done(done_v[0]), .pass(pass_v[0]), .err_cnt(err_v[0]), .match_cnt(match_v[0]),
      .timeout_flag(tmo_v[0]), .ovf_flag(ovf_v[0]), .first_err_ch(fch_v[0]),
      .first_err_idx(fidx_v[0]));

   tb_multi_ch_result_checker #(.N_CH(N_CH), .DATA_W(DW), .EXP_DEPTH(DEPTH), .CNT_W(32),
                                .TOL(1), .TIMEOUT(TMO)) u1 (
      .clk(clk), .rst(rst), .bus(if1), .start(start), .n_expected(n_expected),
      .done(done_v[1]), .pass(pass_v[1]), .err_cnt(err_v[1]), .match_cnt(match_v[1]),
      .timeout_flag(tmo_v[1]), .ovf_flag(ovf_v[1]), .first_err_ch(fch_v[1]),
      .first_err_idx(fidx_v[1]));

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s inst%0d t=%0t got %h expected %h", name, k, $time, act, exp);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   logic [31:0] mq [2][N_CH][$];
   int unsigned m_err[2], m_match[2], m_idle[2], m_nexp[2], m_fidx[2], m_fch[2];
   int unsigned m_beat[2][N_CH];
   bit          m_run[2], m_done[2], m_tmo[2], m_ovf[2], m_seen[2];

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_err[k] = 0; m_match[k] = 0; m_idle[k] = 0; m_nexp[k] = 0; m_fidx[k] = 0; m_fch[k] = 0;
         m_run[k] = 0; m_done[k] = 0; m_tmo[k] = 0; m_ovf[k] = 0; m_seen[k] = 0;
         for (int c = 0; c < int'(N_CH); c++) begin
            mq[k][c].delete();
            m_beat[k][c] = 0;
         end
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         bit run;
         run = m_run[k] && !start;
         if (run) begin
            for (int c = 0; c < int'(N_CH); c++) begin
               if (if0.dut_vld[c]) begin
                  bit bad;
                  bad = 1'b0;
                  if (mq[k][c].size() == 0) bad = 1'b1;
                  else begin
                     logic [31:0] e, g;
                     longint d;
                     e = mq[k][c].pop_front();
                     g = if0.dut_data[c*32 +: 32];
                     d = longint'($signed(g)) - longint'($signed(e));
                     if (d < 0) d = -d;
                     if (d <= longint'(k)) m_match[k]++;
                     else bad = 1'b1;
                  end
                  if (bad) begin
                     m_err[k]++;
                     if (!m_seen[k]) begin
                        m_seen[k] = 1'b1;
                        m_fch[k]  = c;
                        m_fidx[k] = m_beat[k][c];
                     end
                  end
                  m_beat[k][c]++;
               end
            end
         end
         for (int c = 0; c < int'(N_CH); c++) begin
            if (if0.exp_wr_en[c]) begin
               if (mq[k][c].size() < DEPTH) mq[k][c].push_back(if0.exp_wr_data[c*32 +: 32]);
               else m_ovf[k] = 1'b1;
            end
         end
         if (start) begin
            m_err[k] = 0; m_match[k] = 0; m_idle[k] = 0; m_tmo[k] = 0; m_seen[k] = 0;
            m_fch[k] = 0; m_fidx[k] = 0; m_nexp[k] = n_expected;
            m_run[k] = (n_expected != 0); m_done[k] = (n_expected == 0);
            for (int c = 0; c < int'(N_CH); c++) m_beat[k][c] = 0;
         end else if (m_run[k]) begin
            if (|if0.dut_vld) m_idle[k] = 0;
            else if (m_idle[k] != 32'hFFFF_FFFF) m_idle[k]++;
            if (m_match[k] + m_err[k] >= m_nexp[k]) begin
               m_run[k] = 0; m_done[k] = 1;
            end else if (m_idle[k] == TMO) begin
               m_run[k] = 0; m_done[k] = 1; m_tmo[k] = 1;
            end
         end
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else     model_step();
   end

   // Every-cycle comparison of both instances against the model
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            logic [3:0] mf;
            for (int c = 0; c < int'(N_CH); c++) mf[c] = (mq[k][c].size() == DEPTH);
            chk("done", k, 32'(done_v[k]), 32'(m_done[k]));
            chk("pass", k, 32'(pass_v[k]),
                32'(m_done[k] && m_err[k] == 0 && !m_tmo[k] && !m_ovf[k]));
            chk("err_cnt", k, err_v[k], m_err[k]);
            chk("match_cnt", k, match_v[k], m_match[k]);
            chk("timeout_flag", k, 32'(tmo_v[k]), 32'(m_tmo[k]));
            chk("ovf_flag", k, 32'(ovf_v[k]), 32'(m_ovf[k]));
            chk("first_err_ch", k, 32'(fch_v[k]), m_fch[k]);
            chk("first_err_idx", k, fidx_v[k], m_fidx[k]);
            chk("exp_full", k, 32'(full_v[k]), 32'(mf));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   logic [31:0] w [N_CH][8];
   logic [31:0] sq [N_CH][$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic write_all(input logic [3:0] en, input logic [127:0] d);
      if0.exp_wr_en = en; if0.exp_wr_data = d;
      tick();
      if0.exp_wr_en = '0;
   endtask

   task automatic beat(input logic [3:0] m, input logic [127:0] d);
      if0.dut_vld = m; if0.dut_data = d;
      tick();
      if0.dut_vld = '0;
   endtask

   task automatic go(input logic [31:0] n);
      n_expected = n; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int cyc);
      cyc = 0;
      while (!done_v[0] && cyc < budget) begin
         tick();
         cyc++;
      end
      if (!done_v[0]) chk("wait_done_budget", 0, 32'(done_v[0]), 32'd1);
   endtask

   task automatic fill_w();
      for (int c = 0; c < int'(N_CH); c++)
         for (int i = 0; i < 8; i++) w[c][i] = $urandom;
   endtask

   task automatic load_w(input int n);
      logic [127:0] d;
      for (int i = 0; i < n; i++) begin
         for (int c = 0; c < int'(N_CH); c++) d[c*32 +: 32] = w[c][i];
         write_all(4'hF, d);
      end
   endtask

   task automatic feed_w(input int first, input int n);
      logic [127:0] d;
      for (int i = first; i < first + n; i++) begin
         for (int c = 0; c < int'(N_CH); c++) d[c*32 +: 32] = w[c][i];
         beat(4'hF, d);
      end
   endtask

   function automatic logic [31:0] rnd_word();
      case ($urandom_range(0, 5))
         0:       return 32'h8000_0000;
         1:       return 32'h7FFF_FFFF;
         2:       return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      logic [127:0] d;
      rst = 1'b0; start = 1'b0; n_expected = '0;
      if0.exp_wr_en = '0; if0.exp_wr_data = '0; if0.dut_vld = '0; if0.dut_data = '0;
      #1;
      do_reset();
      chk_en = 1'b1;
      chk("reset_done", 0, 32'(done_v[0]), 32'd0);
      chk("reset_pass", 0, 32'(pass_v[0]), 32'd0);

      // Clean run: 8 words per channel, identical data
      fill_w(); load_w(8); go(32); feed_w(0, 8);
      chk("A_done", 0, 32'(done_v[0]), 32'd1);
      chk("A_match", 0, match_v[0], 32'd32);
      chk("A_err", 0, err_v[0], 32'd0);
      chk("A_pass", 0, 32'(pass_v[0]), 32'd1);

      // Single off-by-one on ch2 beat 5
      do_reset(); fill_w(); w[2][5] = 32'h4000_0000;
      load_w(8); go(32);
      feed_w(0, 5);
      for (int c = 0; c < int'(N_CH); c++) d[c*32 +: 32] = w[c][5];
      d[2*32 +: 32] = 32'h4000_0001;
      beat(4'hF, d);
      feed_w(6, 2);
      chk("B_err", 0, err_v[0], 32'd1);
      chk("B_first_ch", 0, 32'(fch_v[0]), 32'd2);
      chk("B_first_idx", 0, fidx_v[0], 32'd5);
      chk("B_pass", 0, 32'(pass_v[0]), 32'd0);
      chk("B_tol_match", 1, match_v[1], 32'd32);
      chk("B_tol_pass", 1, 32'(pass_v[1]), 32'd1);

      // ch1 and ch3 fail in the same cycle
      do_reset(); fill_w(); load_w(2); go(8); feed_w(0, 1);
      for (int c = 0; c < int'(N_CH); c++) d[c*32 +: 32] = w[c][1];
      d[1*32 +: 32] = w[1][1] + 32'd5;
      d[3*32 +: 32] = w[3][1] - 32'd5;
      beat(4'hF, d);
      chk("C_err", 0, err_v[0], 32'd2);
      chk("C_first_ch", 0, 32'(fch_v[0]), 32'd1);
      chk("C_first_idx", 0, fidx_v[0], 32'd1);
      chk("C_match", 0, match_v[0], 32'd6);

      // Underflow, then overflow of a DONE checker's FIFO 0
      do_reset(); go(1);
      beat(4'b0001, {4{32'h1234_5678}});
      chk("D_err", 0, err_v[0], 32'd1);
      chk("D_done", 0, 32'(done_v[0]), 32'd1);
      for (int i = 0; i < 16; i++) write_all(4'b0001, {4{$urandom}});
      chk("D_full", 0, 32'(full_v[0]), 32'd1);
      chk("D_no_ovf_yet", 0, 32'(ovf_v[0]), 32'd0);
      write_all(4'b0001, {4{$urandom}});
      chk("D_ovf", 0, 32'(ovf_v[0]), 32'd1);

      // Timeout after 4 of 10 beats
      do_reset(); fill_w();
      for (int i = 0; i < 4; i++) write_all(4'b0001, {96'd0, w[0][i]});
      go(10);
      for (int i = 0; i < 4; i++) beat(4'b0001, {96'd0, w[0][i]});
      wait_done(300, cyc);
      chk("E_latency", 0, 32'(cyc), 32'd100);
      chk("E_timeout", 0, 32'(tmo_v[0]), 32'd1);
      chk("E_pass", 0, 32'(pass_v[0]), 32'd0);
      chk("E_match", 0, match_v[0], 32'd4);

      // Asynchronous reset mid-run, then a clean restart
      do_reset(); fill_w(); load_w(8); go(32); feed_w(0, 3);
      #2 rst = 1'b1;
      #1;
      chk("F_rst_match", 0, match_v[0], 32'd0);
      chk("F_rst_full", 0, 32'(full_v[0]), 32'd0);
      chk("F_rst_done", 1, 32'(done_v[1]), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      fill_w(); load_w(8); go(32); feed_w(0, 8);
      chk("F_restart_pass", 0, 32'(pass_v[0]), 32'd1);
      chk("F_restart_match", 0, match_v[0], 32'd32);

      // Randomized rounds, restarting from DONE each time
      do_reset();
      for (int r = 0; r < 30; r++) begin
         int cnt [N_CH];
         int mx, total, guard;
         logic [3:0] en, m;
         mx = 0; total = 0;
         for (int c = 0; c < int'(N_CH); c++) begin
            cnt[c] = $urandom_range(0, 8);
            total += cnt[c];
            if (cnt[c] > mx) mx = cnt[c];
         end
         for (int i = 0; i < mx; i++) begin
            for (int c = 0; c < int'(N_CH); c++) begin
               en[c] = (i < cnt[c]);
               d[c*32 +: 32] = rnd_word();
               if (en[c]) sq[c].push_back(d[c*32 +: 32]);
            end
            write_all(en, d);
         end
         go(32'(total));
         guard = 0;
         while ((sq[0].size() + sq[1].size() + sq[2].size() + sq[3].size()) != 0 && guard < 1000) begin
            m = 4'($urandom_range(0, 15));
            for (int c = 0; c < int'(N_CH); c++) begin
               logic [31:0] e;
               if (sq[c].size() == 0) m[c] = 1'b0;
               d[c*32 +: 32] = $urandom;
               if (m[c]) begin
                  e = sq[c].pop_front();
                  case ($urandom_range(0, 9))
                     0:       d[c*32 +: 32] = e + 32'd1;
                     1:       d[c*32 +: 32] = e - 32'd1;
                     2:       d[c*32 +: 32] = e + 32'd2;
                     3:       d[c*32 +: 32] = $urandom;
                     default: d[c*32 +: 32] = e;
                  endcase
               end
            end
            beat(m, d);
            guard++;
         end
         wait_done(300, cyc);
      end

      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
